apb4_mem_slave: RTL and testbench
=================================

Name: apb4_mem_slave

Overview:
- Next-generation APB memory slave: APB4 protocol with byte strobes (PSTRB), protection check (PPROT), PSLVERR error response, parametrised depth and wait states.
- PREADY, PSLVERR and PRDATA are fully registered; PRDATA is zero-driven, never tri-stated.
- Sits behind the AHB-to-APB bridge as a word-organised RAM target.

Parameters:
- ADDR_WIDTH, 16, PADDR width (byte address).
- DATA_WIDTH, 32, data width; legal values 8/16/32/64.
- DEPTH, 1024, number of DATA_WIDTH words; legal range 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 1, PREADY-low cycles inserted in the access phase; legal range 0..15.
- PRIV_ONLY, 0, when 1, unprivileged accesses (PPROT[0]=0) are rejected with PSLVERR.

Ports:
- PCLK in 1: clock, all logic on rising edge.
- PRESETn in 1: asynchronous active-low reset.
- PSEL in 1: slave select.
- PENABLE in 1: access phase.
- PWRITE in 1: 1=write, 0=read.
- PADDR in ADDR_WIDTH: byte address.
- PWDATA in DATA_WIDTH: write data.
- PSTRB in DATA_WIDTH/8: write byte-lane enables.
- PPROT in 3: protection attributes; only bit 0 (privileged) is used.
- PRDATA out DATA_WIDTH: read data.
- PREADY out 1: transfer complete.
- PSLVERR out 1: error response, valid only while PREADY=1.

Behaviour:
- Reset (asynchronous, takes effect immediately at any point, including mid-transfer):
  - PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, wait counter=0.
  - Memory array is not reset and keeps its contents.
- Word index = PADDR >> log2(DATA_WIDTH/8); the low address bits are ignored (no misalignment error).
- Error condition: index >= DEPTH, or (PRIV_ONLY=1 and PPROT[0]=0). The condition is evaluated from the setup-phase address and attributes.
- FSM states:
  - IDLE -> SETUP on PSEL=1, PENABLE=0.
  - SETUP: load counter=WAIT_STATES; go to ACCESS.
  - ACCESS: while counter>0, decrement with PREADY=0. At the edge where counter==0, register PREADY=1, PSLVERR=err and PRDATA; go to DONE.
  - DONE: the cycle in which PREADY=1 is visible.
  - DONE -> SETUP if PSEL=1, PENABLE=0 (back-to-back transfer); else IDLE.
- Timing: transfer length = 2 + WAIT_STATES cycles (setup + access); PREADY is high for exactly 1 cycle.
- Read:
  - PRDATA = mem[index] when there is no error, 0 on error.
  - PRDATA returns to 0 the cycle after DONE.
- Write:
  - Commits at the DONE-cycle edge (PSEL & PENABLE & PREADY & PWRITE & !err).
  - Byte lane i is written only if PSTRB[i]=1. PSTRB=0 is legal and writes nothing (no error).
- Errored transfers never modify memory. PSLVERR=1 only in the DONE cycle; 0 otherwise.
- Protocol violations:
  - PSEL dropping during ACCESS -> return to IDLE, no write, PREADY stays 0.
  - PENABLE=1 seen in IDLE -> ignored.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT are held by the master from setup to completion; no internal capture is required beyond the registered outputs.

Test Plan:
- WAIT_STATES=1: write 0xDEADBEEF to 0x0010 with PSTRB=0xF, then read 0x0010 -> PREADY low for 1 access cycle then high; 3-cycle transfer; PRDATA=0xDEADBEEF, PSLVERR=0.
- Strobes: preload 0x11223344 at 0x0020; write 0xAABBCCDD with PSTRB=0x5 -> readback 0x11BB33DD; PSTRB=0x0 -> readback unchanged.
- Out of range (DEPTH=1024): write to byte address 0x1000 (index 1024) -> PSLVERR=1 with PREADY; the read that follows returns PRDATA=0 with PSLVERR=1; index 1023 (0x0FFC) -> PSLVERR=0.
- PRIV_ONLY=1: write with PPROT=3'b000 -> PSLVERR=1 and memory unchanged; same write with PPROT=3'b001 -> succeeds and readback matches.
- WAIT_STATES=0, back-to-back: four writes then four reads with PSEL held high -> each transfer takes 2 cycles, PREADY pulses every 2nd cycle, data matches.
- Reset mid-access: assert PRESETn=0 during the wait state of a write -> PREADY/PSLVERR/PRDATA=0 immediately, target word unchanged, previously written words preserved after reset release.

Source files
------------

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master (bridge or bench) and the memory slave.
interface apb4_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [2:0]                PPROT;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  // Handshake: a transfer is one setup cycle (PSEL=1, PENABLE=0) followed by
  // access cycles (PSEL=1, PENABLE=1) until PREADY=1; PSLVERR and PRDATA are
  // meaningful only in that PREADY=1 cycle. The master holds PADDR, PWRITE,
  // PWDATA, PSTRB and PPROT stable from setup until completion.
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// APB4 word-organised RAM target with byte strobes, privilege check,
// programmable wait states and fully registered PREADY/PSLVERR/PRDATA.
module apb4_mem_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter bit PRIV_ONLY   = 1'b0
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb4_mem_slave_if.slave      bus,
  output logic [1:0]           dbg_state_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(BYTES);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]       CNT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    pready_q;
  logic                    pslverr_q;
  logic [DATA_WIDTH-1:0]   prdata_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]        idx;
  logic [MEM_AW-1:0]       mem_idx;
  logic                    range_err;
  logic                    priv_err;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    wr_en;
  logic                    unused_bits;

  // Master holds address and attributes from setup to completion, so the
  // error decision taken from the live bus equals the setup-phase decision.
  assign idx       = bus.PADDR[ADDR_WIDTH-1:OFFS];
  assign mem_idx   = idx[MEM_AW-1:0];
  assign range_err = ({1'b0, idx} >= DEPTH_LIM);
  assign priv_err  = PRIV_ONLY && !bus.PPROT[0];
  assign err       = range_err || priv_err;
  assign rd_word   = (!bus.PWRITE && !err) ? mem[mem_idx] : '0;
  assign unused_bits = ^{bus.PPROT[2:1], bus.PADDR};

  // The setup cycle is observed in IDLE; cnt_q holds the wait cycles still
  // to run after the current one, so completion is registered at cnt_q==0.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= err;
              prdata_q  <= rd_word;
              state_q   <= DONE;
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            pready_q  <= 1'b1;
            pslverr_q <= err;
            prdata_q  <= rd_word;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= IDLE;
        end
        default: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign wr_en = (state_q == DONE) && bus.PSEL && bus.PENABLE && pready_q &&
                 bus.PWRITE && !err;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.PSTRB[b]) mem[mem_idx][b*8 +: 8] <= bus.PWDATA[b*8 +: 8];
      end
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: three instances (1 wait state, privileged
// only, zero wait states) share one driver, selected one at a time.
module tb_apb4_mem_slave;

  logic        pclk;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int          sel;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  apb4_mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
  apb4_mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();
  apb4_mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus2 ();
  logic [1:0] dbg0, dbg1, dbg2;

  assign bus0.PSEL = psel && (sel == 0);
  assign bus1.PSEL = psel && (sel == 1);
  assign bus2.PSEL = psel && (sel == 2);
  assign {bus0.PENABLE, bus0.PWRITE, bus0.PADDR, bus0.PWDATA, bus0.PSTRB, bus0.PPROT} =
         {penable, pwrite, paddr, pwdata, pstrb, pprot};
  assign {bus1.PENABLE, bus1.PWRITE, bus1.PADDR, bus1.PWDATA, bus1.PSTRB, bus1.PPROT} =
         {penable, pwrite, paddr, pwdata, pstrb, pprot};
  assign {bus2.PENABLE, bus2.PWRITE, bus2.PADDR, bus2.PWDATA, bus2.PSTRB, bus2.PPROT} =
         {penable, pwrite, paddr, pwdata, pstrb, pprot};

  apb4_mem_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1), .PRIV_ONLY(1'b0))
    u_ws1 (.PCLK(pclk), .PRESETn(rst_n), .bus(bus0.slave), .dbg_state_o(dbg0));
  apb4_mem_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1), .PRIV_ONLY(1'b1))
    u_priv (.PCLK(pclk), .PRESETn(rst_n), .bus(bus1.slave), .dbg_state_o(dbg1));
  apb4_mem_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0), .PRIV_ONLY(1'b0))
    u_ws0 (.PCLK(pclk), .PRESETn(rst_n), .bus(bus2.slave), .dbg_state_o(dbg2));

  logic        cur_ready, cur_err;
  logic [31:0] cur_rdata;
  logic [1:0]  cur_dbg;

  always_comb begin
    cur_ready = bus0.PREADY;
    cur_err   = bus0.PSLVERR;
    cur_rdata = bus0.PRDATA;
    cur_dbg   = dbg0;
    if (sel == 1) begin
      cur_ready = bus1.PREADY; cur_err = bus1.PSLVERR; cur_rdata = bus1.PRDATA; cur_dbg = dbg1;
    end else if (sel == 2) begin
      cur_ready = bus2.PREADY; cur_err = bus2.PSLVERR; cur_rdata = bus2.PRDATA; cur_dbg = dbg2;
    end
  end

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left just after a rising edge. Returns the PREADY cycle's
  // PRDATA/PSLVERR and the transfer length in cycles (setup included).
  task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input logic b2b,
                          output logic [31:0] rd, output logic er, output int cyc);
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    chk("setup_quiet", {cur_ready, cur_err, cur_rdata}, 32'h0);
    @(posedge pclk); #1 penable = 1'b1;
    cyc = 2;
    @(negedge pclk);
    while (!cur_ready && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
      @(negedge pclk);
    end
    rd = cur_rdata;
    er = cur_err;
    @(posedge pclk); #1 penable = 1'b0;
    if (!b2b) psel = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    int          dut;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        b2b;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, int d, logic w, logic [15:0] a, logic [31:0] wd,
                              logic [3:0] s, logic [2:0] p, logic b, logic [31:0] er,
                              logic ee, int c);
    vec_t v;
    v.name = n; v.dut = d; v.wr = w; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p;
    v.b2b = b; v.exp_rdata = er; v.exp_err = ee; v.exp_cyc = c;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;

    // WAIT_STATES=1, DEPTH=1024
    vecs.push_back(mk("w_beef",      0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0,        0, 3));
    vecs.push_back(mk("r_beef",      0, 0, 16'h0010, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0, 3));
    vecs.push_back(mk("r_lowbits",   0, 0, 16'h0013, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0, 3));
    vecs.push_back(mk("w_preload",   0, 1, 16'h0020, 32'h11223344, 4'hF, 3'b000, 0, 32'h0,        0, 3));
    vecs.push_back(mk("w_strb5",     0, 1, 16'h0020, 32'hAABBCCDD, 4'h5, 3'b000, 0, 32'h0,        0, 3));
    vecs.push_back(mk("r_strb5",     0, 0, 16'h0020, 32'h0,        4'h0, 3'b000, 0, 32'h11BB33DD, 0, 3));
    vecs.push_back(mk("w_strb0",     0, 1, 16'h0020, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 32'h0,        0, 3));
    vecs.push_back(mk("r_strb0",     0, 0, 16'h0020, 32'h0,        4'h0, 3'b000, 0, 32'h11BB33DD, 0, 3));
    vecs.push_back(mk("w_idx0",      0, 1, 16'h0000, 32'h0000AAAA, 4'hF, 3'b000, 0, 32'h0,        0, 3));
    vecs.push_back(mk("w_oor",       0, 1, 16'h1000, 32'h12345678, 4'hF, 3'b000, 0, 32'h0,        1, 3));
    vecs.push_back(mk("r_oor",       0, 0, 16'h1000, 32'h0,        4'h0, 3'b000, 0, 32'h0,        1, 3));
    vecs.push_back(mk("r_idx0_kept", 0, 0, 16'h0000, 32'h0,        4'h0, 3'b000, 0, 32'h0000AAAA, 0, 3));
    vecs.push_back(mk("w_last",      0, 1, 16'h0FFC, 32'hCAFEF00D, 4'hF, 3'b000, 0, 32'h0,        0, 3));
    vecs.push_back(mk("r_last",      0, 0, 16'h0FFC, 32'h0,        4'h0, 3'b000, 0, 32'hCAFEF00D, 0, 3));
    // PRIV_ONLY=1
    vecs.push_back(mk("p_w_priv",    1, 1, 16'h0040, 32'h11111111, 4'hF, 3'b001, 0, 32'h0,        0, 3));
    vecs.push_back(mk("p_w_user",    1, 1, 16'h0040, 32'h22222222, 4'hF, 3'b000, 0, 32'h0,        1, 3));
    vecs.push_back(mk("p_r_kept",    1, 0, 16'h0040, 32'h0,        4'h0, 3'b001, 0, 32'h11111111, 0, 3));
    vecs.push_back(mk("p_r_user",    1, 0, 16'h0040, 32'h0,        4'h0, 3'b000, 0, 32'h0,        1, 3));
    vecs.push_back(mk("p_w_priv2",   1, 1, 16'h0040, 32'h33333333, 4'hF, 3'b001, 0, 32'h0,        0, 3));
    vecs.push_back(mk("p_r_new",     1, 0, 16'h0040, 32'h0,        4'h0, 3'b001, 0, 32'h33333333, 0, 3));
    // WAIT_STATES=0, back-to-back with PSEL held
    vecs.push_back(mk("z_w0", 2, 1, 16'h0000, 32'hA0A0A0A0, 4'hF, 3'b000, 1, 32'h0,        0, 2));
    vecs.push_back(mk("z_w1", 2, 1, 16'h0004, 32'hB1B1B1B1, 4'hF, 3'b000, 1, 32'h0,        0, 2));
    vecs.push_back(mk("z_w2", 2, 1, 16'h0008, 32'hC2C2C2C2, 4'hF, 3'b000, 1, 32'h0,        0, 2));
    vecs.push_back(mk("z_w3", 2, 1, 16'h000C, 32'hD3D3D3D3, 4'hF, 3'b000, 1, 32'h0,        0, 2));
    vecs.push_back(mk("z_r0", 2, 0, 16'h0000, 32'h0,        4'h0, 3'b000, 1, 32'hA0A0A0A0, 0, 2));
    vecs.push_back(mk("z_r1", 2, 0, 16'h0004, 32'h0,        4'h0, 3'b000, 1, 32'hB1B1B1B1, 0, 2));
    vecs.push_back(mk("z_r2", 2, 0, 16'h0008, 32'h0,        4'h0, 3'b000, 1, 32'hC2C2C2C2, 0, 2));
    vecs.push_back(mk("z_r3", 2, 0, 16'h000C, 32'h0,        4'h0, 3'b000, 0, 32'hD3D3D3D3, 0, 2));

    // ---------------- reset ----------------
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; sel = 0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset_outs_%0d", s), {cur_ready, cur_err, cur_rdata}, 32'h0);
      chk($sformatf("reset_state_%0d", s), 32'(cur_dbg), 32'h0);
    end
    sel = 0;
    @(posedge pclk); #1 rst_n = 1'b1;
    @(posedge pclk); #1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      sel = vecs[i].dut;
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
               vecs[i].b2b, rd, er, cyc);
      chk({vecs[i].name, "_cyc"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) chk({vecs[i].name, "_data"}, rd, vecs[i].exp_rdata);
    end

    // ---------------- PSEL dropped during access ----------------
    sel = 0;
    pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'b000;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("abort_no_ready", {cur_ready, cur_err, cur_rdata}, 32'h0);
    end
    @(posedge pclk); #1;
    apb_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, cyc);
    chk("abort_no_write", rd, 32'hDEADBEEF);

    // ---------------- reset in the wait state of a write ----------------
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hCAFEF00D);
    pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h55555555; pstrb = 4'hF; pprot = 3'b000;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    chk("wait_ready_low", 32'(cur_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_outs", {cur_ready, cur_err, cur_rdata}, 32'h0);
    chk("rst_wait_state", 32'(cur_dbg), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 rst_n = 1'b1;
    apb_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, cyc);
    chk("rst_target_kept", rd, exp_q.pop_front());
    apb_xfer(1'b0, 16'h0FFC, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, cyc);
    chk("rst_other_kept", rd, exp_q.pop_front());

    // ---------------- reset while PREADY/PRDATA are high ----------------
    pwrite = 1'b0; paddr = 16'h0FFC; pstrb = 4'h0; pprot = 3'b000;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("done_ready", 32'(cur_ready), 32'h1);
    chk("done_data", cur_rdata, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_outs", {cur_ready, cur_err, cur_rdata}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 rst_n = 1'b1;
    apb_xfer(1'b0, 16'h0FFC, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, cyc);
    chk("rst_done_kept", rd, 32'hCAFEF00D);
    chk("rst_done_cyc", 32'(cyc), 32'd3);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
